// File: rtl/image_pkg.sv
// Shared constants and types for the image memory path.
package image_pkg;

  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int PIX_W = 8;

  // Capture FSM states of the frame writer.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DONE  = 2'd2
  } wr_state_t;

endpackage

// File: rtl/image_ram.sv
// Simple dual-port frame memory: one write port, one registered read port.
// A read colliding with a write to the same address returns the old data.
// Addresses at or beyond LENGTH read back as zero.
module image_ram #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 65536,
  parameter int ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [31:0]       raddr,
  output logic [WIDTH-1:0]  rd
);

  logic [WIDTH-1:0]  mem_q [LENGTH];
  logic [WIDTH-1:0]  rd_q;
  logic              raddr_ok_s;
  logic [ADDR_W-1:0] raddr_s;

  // Range check at the full 32-bit width, only then truncate.
  assign raddr_ok_s = (raddr < 32'(LENGTH));
  assign raddr_s    = raddr[ADDR_W-1:0];
  assign rd         = rd_q;

  // Pixel array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read, sees pre-write contents on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (raddr_ok_s) begin
      rd_q <= mem_q[raddr_s];
    end else begin
      rd_q <= '0;
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// Captures one raster-order frame from a valid/ready pixel stream into the
// frame memory and exposes a registered read port for downstream consumers.
module image_frame_writer
  import image_pkg::*;
#(
  parameter int WIDTH  = PIX_W,
  parameter int LENGTH = IMG_W * IMG_H,
  parameter int ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  input  logic [31:0]       r_addr,
  output logic [WIDTH-1:0]  rd,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W:0]   wr_count
);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              in_ready_q, busy_q, frame_done_q;
  logic              xfer_s, we_s;

  // in_ready_q is high exactly in WRITE, so it doubles as the state gate.
  assign xfer_s     = in_valid & in_ready_q;
  assign we_s       = xfer_s & ~abort;

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign wr_count   = count_q;

  // Next-state logic: start only in IDLE, abort only in WRITE and it wins
  // over a same-cycle transfer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      WR_IDLE: begin
        if (start) begin
          state_d = WR_WRITE;
          addr_d  = {ADDR_W{1'b0}};
          count_d = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = WR_IDLE;
        end
      end
      WR_WRITE: begin
        if (abort) begin
          state_d = WR_IDLE;
        end else if (xfer_s) begin
          count_d = count_q + (ADDR_W+1)'(1);
          if (addr_q == ADDR_W'(LENGTH - 1)) begin
            state_d = WR_DONE;
            addr_d  = {ADDR_W{1'b0}};
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = WR_WRITE;
        end
      end
      WR_DONE: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  // State, counters and state-decoded outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      addr_q       <= {ADDR_W{1'b0}};
      count_q      <= {(ADDR_W+1){1'b0}};
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      in_ready_q   <= (state_d == WR_WRITE);
      busy_q       <= (state_d == WR_WRITE) || (state_d == WR_DONE);
      frame_done_q <= (state_d == WR_DONE);
    end
  end

  image_ram #(
    .WIDTH  (WIDTH),
    .LENGTH (LENGTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .waddr (addr_q),
    .wdata (in_data),
    .raddr (r_addr),
    .rd    (rd)
  );

endmodule

// File: tb/tb_image_frame_writer.sv
// Self-checking bench for image_frame_writer with LENGTH=16, WIDTH=8.
// A transaction-level model (pixel list, capture phase, pixel count) predicts
// every output after every clock edge.
module tb_image_frame_writer;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 16;

  localparam int P_IDLE = 0;
  localparam int P_CAP  = 1;
  localparam int P_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] r_addr = 32'h0;
  logic [7:0]  rd;
  logic        busy;
  logic        frame_done;
  logic [4:0]  wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_mem   [LENGTH];
  bit         m_known [LENGTH];
  int         m_phase = P_IDLE;
  int         m_count = 0;

  image_frame_writer #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .r_addr     (r_addr),
    .rd         (rd),
    .busy       (busy),
    .frame_done (frame_done),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".in_ready"},   {31'd0, in_ready},   (m_phase == P_CAP)  ? 32'd1 : 32'd0);
    check({tag, ".busy"},       {31'd0, busy},       (m_phase != P_IDLE) ? 32'd1 : 32'd0);
    check({tag, ".frame_done"}, {31'd0, frame_done}, (m_phase == P_DONE) ? 32'd1 : 32'd0);
    check({tag, ".wr_count"},   {27'd0, wr_count},   32'(m_count));
  endtask

  // One clock: apply inputs, advance the model, check all outputs after the edge.
  task automatic cycle(input bit s, input bit a, input bit v, input logic [7:0] d,
                       input logic [31:0] ra);
    bit         rd_known;
    logic [7:0] exp_rd;
    start = s; abort = a; in_valid = v; in_data = d; r_addr = ra;
    rd_known = 1'b1;
    exp_rd   = 8'h00;
    if (ra < 32'(LENGTH)) begin
      rd_known = m_known[ra[3:0]];
      exp_rd   = m_mem[ra[3:0]];
    end
    case (m_phase)
      P_CAP: begin
        if (a) m_phase = P_IDLE;
        else if (v) begin
          m_mem[m_count]   = d;
          m_known[m_count] = 1'b1;
          m_count++;
          if (m_count == LENGTH) m_phase = P_DONE;
        end
      end
      P_DONE: m_phase = P_IDLE;
      default: if (s) begin m_phase = P_CAP; m_count = 0; end
    endcase
    @(posedge clk);
    #1;
    check_status("cyc");
    if (rd_known) check("cyc.rd", {24'd0, rd}, {24'd0, exp_rd});
  endtask

  task automatic read_sweep(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'(i));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_count = 0;
  endtask

  initial begin
    for (int i = 0; i < LENGTH; i++) begin m_known[i] = 1'b0; m_mem[i] = 8'h00; end

    // 1. Reset held for three cycles
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_status("reset");
    check("reset.rd", {24'd0, rd}, 32'd0);
    rst_n = 1'b1;

    // 2. Full frame, back-to-back, valid already high during start
    cycle(1'b1, 1'b0, 1'b1, 8'hEE, 32'd0);
    for (int i = 0; i < LENGTH; i++) cycle(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 32'd0);
    check("full.done_pulse", {31'd0, frame_done}, 32'd1);
    check("full.count16", {27'd0, wr_count}, 32'd16);
    cycle(1'b0, 1'b0, 1'b1, 8'h77, 32'd0);
    check("full.busy_fall", {31'd0, busy}, 32'd0);
    read_sweep(LENGTH);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd15);

    // 3. Backpressure: 1,0,0 pattern mixed with random stalls
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int k = 0; k < 200 && m_phase == P_CAP; k++) begin
      bit v;
      v = (k % 3 == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      cycle(1'b0, 1'b0, v, 8'($urandom), 32'd0);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    read_sweep(LENGTH);

    // 4. Abort after 5 pixels, with a same-cycle valid pixel
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'hAA, 32'd0);
    check("abort.count5", {27'd0, wr_count}, 32'd5);
    check("abort.idle", {31'd0, busy}, 32'd0);
    read_sweep(8);

    // 5. Read/write collision and out-of-range reads
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h55, 32'd3);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd3);
    check("coll.new", {24'd0, rd}, 32'h55);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd16);
    check("oor.16", {24'd0, rd}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'hFFFF_FFFF);
    check("oor.max", {24'd0, rd}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'h0001_0003);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 32'd0);

    // 6. Start ignored mid-capture, then reset after 8 pixels
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 32'd0);
    check("restart.count8", {27'd0, wr_count}, 32'd8);
    start = 1'b0; in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status("midreset");
    check("midreset.rd", {24'd0, rd}, 32'd0);
    @(posedge clk);
    #1;
    check_status("midreset.hold");
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'hC1, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'hC2, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00, 32'd0);
    read_sweep(10);

    // 7. Random full frame with random read addresses during capture
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 32'd0);
    for (int k = 0; k < 200 && m_phase == P_CAP; k++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, LENGTH - 1));
      cycle(1'b0, 1'b0, ($urandom_range(0, 2) != 0), 8'($urandom), ra);
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
    read_sweep(LENGTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_frame_writer.md
Name: image_frame_writer

Overview:
Writer side of the team's image memory path. It accepts a raster-order pixel stream over a valid/ready handshake and stores one full frame (default 256x256, 8-bit) into an internal simple dual-port frame memory. It exposes a synchronous read port, so downstream VGA and processing blocks can read the captured frame at the same addresses they use for the read-only image store. It sits between the pixel producer (processing core or UART loader) and the display/read consumers.

Parameters:
WIDTH, 8, pixel width in bits
LENGTH, 65536, pixels per frame (256*256); any value >= 2
ADDR_W, $clog2(LENGTH), internal write-address width (derived; not overridden by users)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin capture of a new frame; sampled only in IDLE
abort  input  1  cancel the capture in progress; sampled only in WRITE
in_valid  input  1  pixel on in_data is valid
in_data  input  WIDTH  pixel value
in_ready  output  1  writer accepts a pixel this cycle
r_addr  input  32  read address
rd  output  WIDTH  read data, registered
busy  output  1  high in WRITE and DONE
frame_done  output  1  one-cycle pulse after the last pixel is written
wr_count  output  ADDR_W+1  pixels written in the current or most recent capture

Behaviour:
- Reset (async, rst_n=0): state=IDLE, write address=0, wr_count=0, in_ready=0, busy=0, frame_done=0, rd=0. Memory contents are not reset.
- FSM states:
  - IDLE -> WRITE on start=1. On entry: address=0, wr_count=0.
  - In WRITE, abort=1 -> IDLE. Abort has priority over a same-cycle transfer, so that pixel is not written. wr_count holds its value and frame_done is not pulsed.
  - WRITE -> DONE on the transfer at address LENGTH-1.
  - DONE -> IDLE unconditionally after 1 cycle. frame_done=1 only while in DONE.
- start is ignored outside IDLE. abort is ignored outside WRITE.
- in_ready is a registered function of state: it is 1 exactly when state=WRITE. It does not depend on in_valid.
- Transfer = in_valid & in_ready. On a transfer: mem[address] <= in_data, address increments by 1, wr_count increments by 1.
- No wrap past LENGTH-1. The FSM leaves WRITE on the last pixel, so in_ready is 0 the next cycle.
- Back-to-back transfers sustain 1 pixel per clock. Stalls (in_valid=0) insert gaps with no side effects.
- Read port:
  - rd <= mem[r_addr] on every rising edge; latency 1 cycle, with no enable.
  - If r_addr >= LENGTH, rd <= 0.
  - Read and write to the same address in the same cycle return the OLD data; new data is visible from the next cycle.
- Reset asserted mid-capture returns to IDLE immediately. Partially written memory is retained, and frame_done does not pulse.
- Width rules: wr_count must reach LENGTH exactly, hence ADDR_W+1 bits. r_addr is compared at full 32 bits before truncation to ADDR_W.

Decomposition:
- Shared package image_pkg:
  - IMG_W=256, IMG_H=256, PIX_W=8 constants
  - typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DONE} wr_state_t
- One sub-module: image_ram, a simple dual-port RAM with parameters WIDTH and LENGTH.
  - Write side: we, waddr, wdata.
  - Read side: raddr, rd, registered, read-old-on-collision.
  - No reset on the array. The FSM and counters stay in image_frame_writer.

Test Plan:
All scenarios use LENGTH=16, WIDTH=8.
1. Reset check: hold rst_n=0 for 3 cycles -> in_ready=0, busy=0, frame_done=0, rd=0, wr_count=0.
2. Full frame: pulse start, then drive in_valid=1 continuously with data 0x10..0x1F -> 16 transfers on consecutive cycles. frame_done is high exactly 1 cycle after the 16th transfer, wr_count=16, busy falls the cycle after. Reading r_addr=0..15 returns 0x10..0x1F, each 1 cycle after its address.
3. Backpressure gaps: toggle in_valid 1,0,0,1,... during WRITE -> only valid cycles are written, and addresses are contiguous with no holes. Memory holds the 16 pixels in order.
4. Abort: start, write 5 pixels, assert abort together with in_valid=1 and data 0xAA -> state IDLE, wr_count=5, no frame_done, mem[5] unchanged.
5. Read collision and out of range: write 0x55 to address 3 while r_addr=3 -> rd shows the old value, then 0x55 on the next read. r_addr=16 or 0xFFFF_FFFF -> rd=0.
6. Start ignored and mid-run reset: pulse start during WRITE -> address does not restart. Assert rst_n=0 after 8 transfers -> immediate IDLE, no frame_done. A new start then begins again at address 0.
